// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words and writes them to
// instruction memory port A while holding the CPU in reset. Optional: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_W     = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state, state_nxt;
    logic [1:0]      byte_cnt;
    logic [ADDR_W:0] word_idx;
    logic [ADDR_W:0] count_q;
    logic [23:0]     shift;
    logic            fin;
    logic            chk;
    logic            chk_fail;
    logic            start_ok;
    logic            start_rej;
    logic            load_start;
    logic            take;
    logic            word_take;
    logic            last_word;

    assign start_ok   = start && (word_count != '0) && (word_count <= MAX_WORDS);
    assign load_start = start_ok && (state != LOAD);
    assign start_rej  = start && !start_ok && (state != LOAD);

    // fin marks the cycle of the final write: the byte port closes while wea is high.
    assign rx_ready   = (state == LOAD) && !fin;
    assign take       = rx_valid && rx_ready;
    assign word_take  = take && !chk && (byte_cnt == 2'd3);
    assign last_word  = word_take && (word_idx == count_q - ONE_W);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_nxt;

    assign sum_nxt  = sum + rx_data;
    assign chk_fail = chk && take && (sum_nxt != 8'h00);
    assign fin      = 1'b0;

    // After the last word, one trailing byte must bring the running sum to zero.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            sum <= '0;
            chk <= 1'b0;
        end else if (load_start) begin
            sum <= '0;
            chk <= 1'b0;
        end else begin
            if (take && !chk) begin
                sum <= sum_nxt;
            end
            if (last_word) begin
                chk <= 1'b1;
            end else if (chk && take) begin
                chk <= 1'b0;
            end
        end
    end
`else
    assign chk      = 1'b0;
    assign chk_fail = 1'b0;

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            fin <= 1'b0;
        end else begin
            fin <= last_word;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        cpu_rst   = 1'b1;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (chk && take) begin
                    state_nxt = chk_fail ? IDLE : DONE;
                end
`else
                if (fin) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                cpu_rst = 1'b0;
                if (load_start) begin
                    state_nxt = LOAD;
                end else if (start_rej) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            wea      <= 1'b0;
            addra    <= '0;
            dina     <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            byte_cnt <= '0;
            word_idx <= '0;
            count_q  <= '0;
            shift    <= '0;
        end else begin
            wea <= word_take;
            if (load_start) begin
                count_q  <= word_count;
                word_idx <= '0;
                byte_cnt <= '0;
                shift    <= '0;
                done     <= 1'b0;
                err      <= 1'b0;
            end else begin
                // Bytes enter at the top and shift down, so byte 0 ends up in [7:0].
                if (take && !chk) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    shift    <= {rx_data, shift[23:8]};
                end
                if (word_take) begin
                    dina     <= {rx_data, shift};
                    addra    <= word_idx[ADDR_W-1:0];
                    word_idx <= word_idx + ONE_W;
                end
                if (start_rej || chk_fail) begin
                    err <= 1'b1;
                end
                if ((state == LOAD) && (state_nxt == DONE)) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; expected writes are queued as bytes are
// sent and popped when wea pulses. Covers the checksum byte when IMEM_LOADER_CHECKSUM_EN is set.
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clka = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [31:0]       dina;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         wr_count = 0;
    int         exp_addr = 0;
    logic [7:0] ck_sum = '0;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clka      (clka),
        .rst_n     (rst_n),
        .start     (start),
        .word_count(word_count),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: every wea pulse must match the oldest queued expectation.
    always @(negedge clka) begin
        if (wea === 1'b1) begin
            wr_t e;
            wr_count++;
            check("wr_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(addra), 32'(e.addr));
                check("wr_data", dina, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic do_start(input int n);
        start      = 1'b1;
        word_count = (ADDR_W+1)'(n);
        tick();
        start    = 1'b0;
        exp_addr = 0;
        ck_sum   = '0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int n;
        if (gaps && ($urandom_range(0, 2) == 0)) begin
            repeat ($urandom_range(1, 3)) tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clka);
            acc = rx_ready;
            tick();
            n++;
        end
        rx_valid = 1'b0;
        check("rx_accept", 32'(acc), 1);
        ck_sum = ck_sum + b;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        wr_t e;
        e.addr = ADDR_W'(exp_addr);
        e.data = w;
        exp_q.push_back(e);
        exp_addr++;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gaps);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clka);
        while (done !== 1'b1 && n < 50) begin
            @(negedge clka);
            n++;
        end
        check("done_seen", 32'(done), 1);
    endtask

    task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'(-ck_sum), 1'b0);
`endif
        wait_done();
    endtask

    initial begin
        int wr0;

        // Reset then idle
        rst_n = 1'b0;
        repeat (2) @(posedge clka);
        #1 rst_n = 1'b1;
        @(negedge clka);
        check("rst_cpu_rst", 32'(cpu_rst), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rx_ready", 32'(rx_ready), 0);
        check("rst_wea", 32'(wea), 0);
        tick();

        // Single word, back-to-back bytes
        do_start(1);
        send_word(32'h0010_0013, 1'b0);
        @(negedge clka);
        check("sw_wea", 32'(wea), 1);
        check("sw_addra", 32'(addra), 0);
        check("sw_dina", dina, 32'h0010_0013);
`ifdef IMEM_LOADER_CHECKSUM_EN
        tick();
        finish_load();
`else
        check("sw_rdy_drop", 32'(rx_ready), 0);
        tick();
        @(negedge clka);
        check("sw_done", 32'(done), 1);
`endif
        check("sw_cpu_rst", 32'(cpu_rst), 0);
        check("sw_busy", 32'(busy), 0);
        tick();

        // Full depth with random rx_valid gaps
        wr0 = wr_count;
        do_start(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            send_word($urandom, 1'b1);
        end
        finish_load();
        check("full_writes", 32'(wr_count - wr0), 32'(DEPTH));
        check("full_q_empty", 32'(exp_q.size()), 0);
        check("full_rx_ready", 32'(rx_ready), 0);
        check("full_last_addr", 32'(addra), 32'(DEPTH - 1));
        check("full_cpu_rst", 32'(cpu_rst), 0);
        repeat (5) tick();
        check("full_no_extra", 32'(wr_count - wr0), 32'(DEPTH));

        // Invalid counts: zero from DONE, then DEPTH+1 from a fresh DONE
        wr0 = wr_count;
        do_start(0);
        @(negedge clka);
        check("inv0_err", 32'(err), 1);
        check("inv0_busy", 32'(busy), 0);
        check("inv0_cpu_rst", 32'(cpu_rst), 1);
        check("inv0_rx_ready", 32'(rx_ready), 0);
        tick();
        do_start(1);
        @(negedge clka);
        check("relo_err_clr", 32'(err), 0);
        check("relo_done_clr", 32'(done), 0);
        check("relo_busy", 32'(busy), 1);
        tick();
        wr0 = wr_count;
        send_word($urandom, 1'b0);
        finish_load();
        tick();
        do_start(DEPTH + 1);
        @(negedge clka);
        check("inv65_err", 32'(err), 1);
        check("inv65_busy", 32'(busy), 0);
        check("inv65_cpu_rst", 32'(cpu_rst), 1);
        repeat (3) tick();
        check("inv_no_write", 32'(wr_count - wr0), 1);

        // Reset after 6 bytes of a 2-word load
        do_start(2);
        wr0 = wr_count;
        send_word(32'hCAFE_F00D, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h5A, 1'b0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clka);
        check("mid_writes", 32'(wr_count - wr0), 1);
        check("mid_q_empty", 32'(exp_q.size()), 0);
        check("mid_wea", 32'(wea), 0);
        check("mid_addra", 32'(addra), 0);
        check("mid_dina", dina, 0);
        check("mid_cpu_rst", 32'(cpu_rst), 1);
        check("mid_busy", 32'(busy), 0);
        check("mid_done", 32'(done), 0);
        check("mid_err", 32'(err), 0);
        tick();
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        repeat (4) tick();
        @(negedge clka);
        check("idle_rx_ready", 32'(rx_ready), 0);
        rx_valid = 1'b0;
        tick();
        check("idle_no_write", 32'(wr_count - wr0), 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Good and bad checksum bytes
        do_start(1);
        send_word(32'h0000_0001, 1'b0);
        send_byte(8'hFF, 1'b0);
        wait_done();
        check("ck_good_err", 32'(err), 0);
        tick();
        do_start(1);
        send_word(32'h0000_0001, 1'b0);
        send_byte(8'h00, 1'b0);
        begin
            int n = 0;
            @(negedge clka);
            while (err !== 1'b1 && n < 20) begin
                @(negedge clka);
                n++;
            end
        end
        check("ck_bad_err", 32'(err), 1);
        check("ck_bad_done", 32'(done), 0);
        check("ck_bad_cpu_rst", 32'(cpu_rst), 1);
        check("ck_bad_busy", 32'(busy), 0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory. It receives a little-endian byte stream over a valid/ready interface, packs each 4 bytes into a 32-bit instruction word, and writes the words into instruction memory port A at sequential word addresses starting at 0. While loading it holds the CPU's program counter in reset. When loading completes it releases the CPU, so fetch starts at address 0 with the new program.

Parameters:
ADDR_W, 6, word-address width of instruction memory (depth = 2^ADDR_W words)
DATA_W, 32, instruction word width; fixed at 32 (4 bytes per word)

Ports:
clka  in  1  clock; all logic on posedge
rst_n  in  1  synchronous reset, active-low
start  in  1  one-cycle pulse; begins a load
word_count  in  ADDR_W+1  number of words to load; sampled on start
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data is valid
rx_ready  out  1  loader accepts a byte this cycle
wea  out  1  instruction memory write enable (one-cycle pulse per word)
addra  out  ADDR_W  instruction memory word address
dina  out  32  instruction memory write data
cpu_rst  out  1  active-high reset to the PC/CPU
busy  out  1  load in progress
done  out  1  last load completed successfully (level)
err  out  1  last start was rejected or the load failed (level)

Behaviour:
- Reset (rst_n=0 at posedge) sets:
  - state=IDLE, cpu_rst=1, rx_ready=0, wea=0, addra=0, dina=0
  - busy=0, done=0, err=0
  - byte counter, word counter and shift register cleared
- A reset mid-load aborts the load; the partial word is discarded and not written.
- States: IDLE, LOAD, DONE.
- IDLE:
  - cpu_rst=1.
  - On start with 1 <= word_count <= 2^ADDR_W: latch word_count, clear done/err, go to LOAD.
  - On start with word_count==0 or word_count > 2^ADDR_W: set err=1, stay in IDLE, no writes.
- LOAD:
  - busy=1, cpu_rst=1, rx_ready=1.
  - A byte is accepted when rx_valid & rx_ready at posedge.
  - Packing is little-endian: bytes 0..3 of a word go to bits [7:0], [15:8], [23:16], [31:24].
  - On acceptance of the 4th byte:
    - dina takes the assembled word and addra the current word index.
    - wea=1 during the following cycle only (1-cycle latency from the 4th handshake).
  - The byte counter wraps 3->0, and a byte accepted in the same cycle as the wea pulse is kept; there are no stall cycles.
  - The word index increments after each write.
  - After the write of word word_count-1: go to DONE; rx_ready drops in the same cycle wea is high.
  - start while in LOAD is ignored.
  - rx_valid=0 simply stalls; there is no timeout.
- DONE:
  - cpu_rst=0, done=1, busy=0, rx_ready=0.
  - addra and dina hold their last values; wea=0.
  - start in DONE re-enters via the IDLE rules in the same cycle: a valid count goes to LOAD (cpu_rst=1 the next cycle, done cleared); an invalid count sets err=1, state=IDLE, cpu_rst=1.
- Addresses never wrap: the maximum count is 2^ADDR_W, so the last address is 2^ADDR_W-1.
- Bytes presented while rx_ready=0 are not consumed.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - An 8-bit modular sum of all payload bytes is kept.
  - After the last word is written, the loader stays in LOAD (a CHECK sub-phase, rx_ready=1) and accepts exactly one more byte.
  - If that byte equals the two's complement of the sum (sum+byte==8'h00): go to DONE.
  - Otherwise: err=1, done=0, cpu_rst stays 1, go to IDLE. Memory contents already written remain.
- Without the macro: no checksum byte is expected; DONE follows the last write directly.

Test Plan:
- Reset then idle: hold rst_n=0 2 cycles, release -> cpu_rst=1, busy=0, done=0, err=0, rx_ready=0, wea=0.
- Single word: start with word_count=1, bytes 8'h13,8'h00,8'h10,8'h00 back-to-back -> one wea pulse the cycle after the 4th byte, addra=0, dina=32'h0010_0013; next cycle done=1, cpu_rst=0.
- Full depth with gaps: word_count=64, random rx_valid gaps -> 64 wea pulses at addra 0..63 in order, data matching the model; no extra write; rx_ready=0 after the last.
- Invalid count: start with word_count=0, then with word_count=65 -> err=1 each time, state IDLE, no wea, cpu_rst=1.
- Reset mid-load: rst_n=0 after 6 bytes of a 2-word load -> exactly one write has occurred (addra=0), second word never written, outputs at reset values.
- Checksum (IMEM_LOADER_CHECKSUM_EN): load word 32'h0000_0001 then byte 8'hFF -> done=1; repeat with 8'h00 -> err=1, done=0, cpu_rst=1.
